// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Build option MULDIV_FAST_MUL_EN: single-cycle multiply that bypasses the CALC state.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted here
// CALC  | one multiply or quotient bit per cycle, counter 31 down to 0
// FIX   | sign correction, HI/LO written
// DONE  | one-cycle completion pulse
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             whi,
    input  logic             wlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [W2-1:0]    acc, acc_mul, acc_div, prod;
    logic [WIDTH-1:0] dsr, a_r, mag_a, mag_b, quo, rem, rem_sub, res_hi, res_lo;
    logic [WIDTH:0]   rem_ext, sum_ext;
    logic [4:0]       cnt;
    logic             is_div, b_zero, neg_q, neg_r, a_neg, b_neg, rem_ge, accept;

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign accept = (state == IDLE) && start && !flush;

    assign a_neg = !op[0] && a[WIDTH-1];
    assign b_neg = !op[0] && b[WIDTH-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    // Multiply: multiplier sits in acc[31:0] and shifts out LSB-first.
    assign sum_ext = {1'b0, acc[W2-1:WIDTH]} + {1'b0, dsr};
    assign acc_mul = acc[0] ? {sum_ext, acc[WIDTH-1:1]} : {1'b0, acc[W2-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; quotient bits enter at the LSB.
    assign rem_ext = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    assign rem_ge  = (rem_ext >= {1'b0, dsr});
    assign rem_sub = rem_ext[WIDTH-1:0] - dsr;
    assign acc_div = {(rem_ge ? rem_sub : rem_ext[WIDTH-1:0]), acc[WIDTH-2:0], rem_ge};

    assign prod = neg_q ? -acc : acc;
    assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_r ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];

    always_comb begin
        res_hi = prod[W2-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                res_hi = a_r;
                res_lo = '1;
            end else begin
                res_hi = rem;
                res_lo = quo;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_nxt = op[1] ? CALC : FIX;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC:    if (cnt == 5'd0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            acc    <= '0;
            dsr    <= '0;
            a_r    <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            b_zero <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_div <= op[1];
                        a_r    <= a;
                        b_zero <= (b == '0);
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        cnt    <= 5'd31;
                        dsr    <= op[1] ? mag_b : mag_a;
                        acc    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
`ifdef MULDIV_FAST_MUL_EN
                        if (!op[1]) acc <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif
                    end else if (!start) begin
                        if (whi) hi <= wdata;
                        if (wlo) lo <= wdata;
                    end
                end
                CALC: begin
                    acc <= is_div ? acc_div : acc_mul;
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                FIX: begin
                    if (!flush) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: arithmetic reference model plus directed vectors.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_ex_muldiv;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0, clrn = 1'b0, start = 1'b0, flush = 1'b0, whi = 1'b0, wlo = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_pass = 0, n_total = 0;

    ex_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .whi(whi), .wlo(wlo), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    function automatic int latency(input logic [1:0] o);
        return (FAST && !o[1]) ? 1 : 33;
    endfunction

    // Architectural result from plain arithmetic.
    function automatic void model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] rh, output logic [31:0] rl);
        longint      p;
        logic [63:0] pu;
        int          sx, sy, q, r;
        sx = x;
        sy = y;
        rh = '0;
        rl = '0;
        case (o)
            2'd0: begin
                p  = longint'(sx) * longint'(sy);
                rh = p[63:32];
                rl = p[31:0];
            end
            2'd1: begin
                pu = {32'd0, x} * {32'd0, y};
                rh = pu[63:32];
                rl = pu[31:0];
            end
            2'd2: begin
                if (y == 32'd0) begin
                    rh = x; rl = 32'hFFFF_FFFF;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    rh = 32'd0; rl = 32'h8000_0000;
                end else begin
                    q = sx / sy; r = sx % sy;
                    rh = r; rl = q;
                end
            end
            default: begin
                if (y == 32'd0) begin
                    rh = x; rl = 32'hFFFF_FFFF;
                end else begin
                    rh = x % y; rl = x / y;
                end
            end
        endcase
    endfunction

    // Cycle-level expectation: edges elapsed since the accepting edge.
    logic        m_active = 1'b0;
    int          m_since = 0, m_lat = 33;
    logic [31:0] m_hi = '0, m_lo = '0, m_rh = '0, m_rl = '0;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_active = 1'b0; m_since = 0; m_hi = '0; m_lo = '0;
        end else if (m_active) begin
            if (flush) m_active = 1'b0;
            else begin
                m_since++;
                if (m_since == m_lat) begin
                    m_hi = m_rh; m_lo = m_rl;
                end else if (m_since == m_lat + 1) m_active = 1'b0;
            end
        end else if (start) begin
            if (!flush) begin
                m_active = 1'b1; m_since = 0; m_lat = latency(op);
                model_op(op, a, b, m_rh, m_rl);
            end
        end else begin
            if (whi) m_hi = wdata;
            if (wlo) m_lo = wdata;
        end
    end

    always @(negedge clk) begin
        chk("cyc busy", {63'd0, busy}, {63'd0, m_active});
        chk("cyc done", {63'd0, done}, {63'd0, (m_active && m_since == m_lat)});
        chk("cyc hi", {32'd0, hi}, {32'd0, m_hi});
        chk("cyc lo", {32'd0, lo}, {32'd0, m_lo});
    end

    // Launch one op from a negedge, wait for done, check latency and literal results.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el);
        int lat;
        lat = -1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin lat = k; break; end
        end
        chk({nm, " latency"}, 64'(lat), 64'(latency(o)));
        chk({nm, " hi"}, {32'd0, hi}, {32'd0, eh});
        chk({nm, " lo"}, {32'd0, lo}, {32'd0, el});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int          d1, d2, lat;
        logic [31:0] sh, sl;
        logic        seen;

        repeat (3) @(negedge clk);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset hi", {32'd0, hi}, 64'd0);
        chk("reset lo", {32'd0, lo}, 64'd0);
        clrn = 1'b1;
        @(negedge clk);

        run_op("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult -3x7", 2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu /0", 2'd3, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF);
        run_op("div ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("div -5/0", 2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("mult minxmin", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
        run_op("div 7/-2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

        // MTHI while idle
        whi = 1'b1; wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        #1 whi = 1'b0;
        chk("mthi idle", {32'd0, hi}, {32'd0, 32'hA5A5_A5A5});
        @(negedge clk);

        // MTLO and a second start while busy are both ignored
        start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd3; wlo = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 begin start = 1'b0; wlo = 1'b0; end
        chk("mtlo busy", {32'd0, lo}, {32'd0, 32'hFFFF_FFFD});
        lat = -1;
        for (int k = 6; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin lat = k; break; end
        end
        chk("restart ignored latency", 64'(lat), 64'd33);
        chk("restart ignored hi", {32'd0, hi}, 64'd2);
        chk("restart ignored lo", {32'd0, lo}, 64'd14);
        @(posedge clk);
        @(negedge clk);

        // Flush at edge N+10 of a divide
        sh = hi; sl = lo;
        start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush busy", {63'd0, busy}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) seen = 1'b1;
        end
        chk("flush no done", {63'd0, seen}, 64'd0);
        chk("flush hi kept", {32'd0, hi}, {32'd0, sh});
        chk("flush lo kept", {32'd0, lo}, {32'd0, sl});
        @(negedge clk);

        // Back-to-back with start held high
        d1 = -1; d2 = -1;
        start = 1'b1; op = 2'd3; a = 32'd50; b = 32'd4;
        @(posedge clk);
        for (int k = 1; k <= 90; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (d1 < 0) d1 = k;
                else begin d2 = k; start = 1'b0; break; end
            end
        end
        start = 1'b0;
        chk("b2b first done", 64'(d1), 64'd33);
        chk("b2b second done", 64'(d2), 64'd68);
        chk("b2b lo", {32'd0, lo}, 64'd12);
        @(posedge clk);
        @(negedge clk);

        // Reset in the middle of CALC
        start = 1'b1; op = 2'd3; a = 32'd9; b = 32'd2;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #2 clrn = 1'b0;
        #1;
        chk("midrst busy", {63'd0, busy}, 64'd0);
        chk("midrst done", {63'd0, done}, 64'd0);
        chk("midrst hi", {32'd0, hi}, 64'd0);
        chk("midrst lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);

        run_op("post-reset divu", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("multu small", 2'd1, 32'd12345, 32'd678, 32'd0, 32'd8369910);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
